trace_entry_spram: RTL and testbench
====================================

// Module: trace_entry_spram
// PURPOSE
// Single-port synchronous RAM behaving as the Xilinx xpm_memory_spram macro in word-wide mode.
// Stores one {mem_addr, instruction} trace record per word for the trace repository.
// One shared address port serves both writes (trace capture) and reads (trace replay).
// Its output is registered and has a configurable read latency.
// PARAMETERS
// ADDR_WIDTH        10      address bits (repository sets $clog2(TRACE_ENTRIES))
// DATA_WIDTH        48      word width (DATA_ADDR_WIDTH 16 + DATA_DATA_WIDTH 32)
// MEMORY_DEPTH      1024    number of words; must be <= 2**ADDR_WIDTH
// READ_LATENCY      1       cycles from read enable to valid douta; legal range 1..2
// READ_RESET_VALUE  'hFF    douta value on reset, zero-extended to DATA_WIDTH
// PORTS
// clk             in   1           rising-edge clock
// rst_n           in   1           asynchronous active-low reset
// ena             in   1           memory enable; an access occurs only on edges with ena=1
// wea             in   1           word write enable (qualified by ena)
// addra           in   ADDR_WIDTH  shared read/write address
// dina            in   DATA_WIDTH  write data
// douta           out  DATA_WIDTH  registered read data
// regcea          in   1           clock enable of the final output stage (READ_LATENCY=2 only)
// sleep           in   1           1 = block all accesses; douta holds
// injectsbiterra  in   1           ignored (no ECC)
// injectdbiterra  in   1           ignored (no ECC)
// BEHAVIOUR
// - Storage: MEMORY_DEPTH x DATA_WIDTH array, all words initialised to 0 at time zero.
// - Reset: rst_n=0 asynchronously forces every output pipeline register to READ_RESET_VALUE.
//   Reset does not alter array contents.
//   Internal pipelined enables clear to 0 during reset.
// - Write: at a rising edge with ena=1, wea=1, sleep=0, mem[addra] <= dina.
//   Write mode is no_change: douta keeps its previous value on write cycles.
// - Read, READ_LATENCY=1: at an edge with ena=1, wea=0, douta <= mem[addra].
//   douta is valid immediately after that edge.
//   regcea is ignored at this latency.
// - Read, READ_LATENCY=2: the stage-1 register captures mem[addra] at the enabled edge.
//   At the next edge, douta <= stage-1 value if regcea=1; otherwise douta holds.
//   The enable is pipelined alongside the data, so only real reads update douta.
// - Idle: with ena=0, no access takes place, the array is unchanged and douta holds.
// - Read-after-write at the same address in consecutive cycles returns the newly written data.
// - Back-to-back reads sustain one per cycle; douta updates every cycle at the configured latency.
// - Out-of-range address (addra >= MEMORY_DEPTH): the write is dropped and a read returns 0.
// - sleep=1 is treated exactly as ena=0.
//   No wake-up latency; normal operation resumes at the next edge after sleep falls.
// - Reset asserted mid-read: the in-flight read is discarded and douta shows the reset value.
//   After rst_n rises, the first valid data is the first read issued after release.
// - No ECC and no error outputs; inject inputs have no effect.
// TESTING
// - Reset: hold rst_n=0, then release -> douta=48'h0000_0000_00FF; array reads back 0 at any address.
// - Write then read: write addr 3 = 48'h1234_DEAD_BEEF, then read addr 3 (latency 1)
//   -> douta=48'h1234_DEAD_BEEF one edge after the read.
// - No-change: douta=X0 after a read, then write addr 5 -> douta stays X0 on the write edge.
// - Streaming: write addr 0..7 with value=addr*3, then read addr 0..7 on consecutive cycles
//   -> douta follows 0,3,...,21 with one-cycle lag.
// - Idle/sleep: ena=0, or sleep=1 with wea=1, addr 2 -> mem[2] unchanged and douta unchanged.
// - Latency 2: read addr 1 with regcea=1 -> data appears two edges later.
//   Same read with regcea=0 -> douta holds.
//   Assert rst_n=0 between the edges -> douta=READ_RESET_VALUE.

Source files
------------

// File: rtl/trace_entry_spram.sv
// trace_entry_spram: single-port synchronous RAM holding one {mem_addr, instruction}
// trace record per word. One shared address port serves capture writes and replay
// reads. Read data is registered with a read latency of 1 or 2 cycles. Write mode
// is no_change: douta is left untouched on write cycles.
module trace_entry_spram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 48,
  parameter int MEMORY_DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = DATA_WIDTH'('hFF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  regcea,
  input  logic                  sleep,
  input  logic                  injectsbiterra,
  input  logic                  injectdbiterra
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  // Array starts all-zero; reset never touches it.
  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH] = '{default: '0};

  logic                  access;
  logic                  wr_en;
  logic                  rd_en;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // sleep behaves exactly like a dropped enable.
  assign access   = ena & ~sleep;
  assign wr_en    = access & wea;
  assign rd_en    = access & ~wea;
  assign in_range = (32'(addra) < 32'(MEMORY_DEPTH));
  assign idx      = IDX_W'(addra);
  // Out-of-range reads return zero rather than aliasing into the array.
  assign rd_word  = in_range ? mem_q[idx] : '0;

  // No ECC on this macro; the error-injection pins are accepted and ignored.
  logic unused_inject;
  assign unused_inject = injectsbiterra ^ injectdbiterra;

  // Array write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && in_range) mem_q[idx] <= dina;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Output register only loads on real reads (no_change on writes/idle).
    always_comb begin
      dout_d = dout_q;
      if (rd_en) dout_d = rd_word;
    end

    // Output register with asynchronous reset to the read reset value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= READ_RESET_VALUE;
      else        dout_q <= dout_d;
    end

    assign douta = dout_q;

    // The final-stage clock enable has no register to act on at this latency.
    logic unused_regce;
    assign unused_regce = regcea;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    logic                  en1_q, en1_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Stage 1 captures read data; its enable travels with it so that only
    // real reads ever reach the output stage.
    always_comb begin
      s1_d   = s1_q;
      en1_d  = rd_en;
      dout_d = dout_q;
      if (rd_en)            s1_d   = rd_word;
      if (en1_q && regcea)  dout_d = s1_q;
    end

    // Both data stages reset to the read reset value; the enable clears, so a
    // read in flight at reset is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q   <= READ_RESET_VALUE;
        en1_q  <= 1'b0;
        dout_q <= READ_RESET_VALUE;
      end else begin
        s1_q   <= s1_d;
        en1_q  <= en1_d;
        dout_q <= dout_d;
      end
    end

    assign douta = dout_q;
  end

endmodule

// File: tb/tb_trace_entry_spram.sv
// Bench for trace_entry_spram: a latency-1 full-depth instance and a latency-2
// instance with a shortened depth share one stimulus stream. A behavioural model
// (plain arrays plus a one-entry pending-read slot) predicts both outputs, and a
// negedge process compares every cycle; directed literals pin the model.
module tb_trace_entry_spram;
  localparam int AW  = 10;
  localparam int DW  = 48;
  localparam int D1  = 1024;
  localparam int D2  = 1000;
  localparam logic [DW-1:0] RRV = 48'h0000_0000_00FF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0, wea = 1'b0, sleep = 1'b0, regcea = 1'b0;
  logic          sbit = 1'b0, dbit = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;
  logic [DW-1:0] dout1, dout2;

  always #5 clk = ~clk;

  trace_entry_spram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_DEPTH(D1),
                      .READ_LATENCY(1), .READ_RESET_VALUE(RRV)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout1), .regcea(regcea), .sleep(sleep),
    .injectsbiterra(sbit), .injectdbiterra(dbit));

  trace_entry_spram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_DEPTH(D2),
                      .READ_LATENCY(2), .READ_RESET_VALUE(RRV)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout2), .regcea(regcea), .sleep(sleep),
    .injectsbiterra(sbit), .injectdbiterra(dbit));

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m1 [D1];
  logic [DW-1:0] m2 [D2];
  logic [DW-1:0] exp1 = RRV, exp2 = RRV, pend_d = '0;
  bit            pend_v = 1'b0;
  int            ma;
  int            pass_cnt = 0, tot_cnt = 0;
  bit            chk_en = 1'b0;

  initial begin
    foreach (m1[i]) m1[i] = '0;
    foreach (m2[i]) m2[i] = '0;
  end

  always @(negedge rst_n) begin
    exp1 = RRV; exp2 = RRV; pend_v = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      exp1 = RRV; exp2 = RRV; pend_v = 1'b0;
    end else begin
      // a read issued one edge ago lands now if the output stage is enabled
      if (pend_v && regcea) exp2 = pend_d;
      pend_v = 1'b0;
      if (ena && !sleep) begin
        ma = int'(addra);
        if (wea) begin
          if (ma < D1) m1[ma] = dina;
          if (ma < D2) m2[ma] = dina;
        end else begin
          exp1   = (ma < D1) ? m1[ma] : '0;
          pend_v = 1'b1;
          pend_d = (ma < D2) ? m2[ma] : '0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u1_douta", dout1, exp1);
      chk("u2_douta", dout2, exp2);
    end
  end

  // apply inputs, then wait past the edge that consumes them
  task automatic drive(input bit e, input bit w, input int a, input logic [DW-1:0] d,
                       input bit s, input bit rc);
    ena = e; wea = w; addra = AW'(a); dina = d; sleep = s; regcea = rc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  bit rr;
  int ra;

  initial begin
    // reset
    repeat (3) drive(0, 0, 0, '0, 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_u1", dout1, 48'h0000_0000_00FF);
    chk("rst_u2", dout2, 48'h0000_0000_00FF);
    chk("rst_mdl", exp1, 48'h0000_0000_00FF);
    drive(1, 0, 9, '0, 0, 1);
    chk("rst_arr_u1", dout1, 48'h0);

    // write then read
    drive(1, 1, 3, 48'h1234_DEAD_BEEF, 0, 1);
    drive(1, 0, 3, '0, 0, 1);
    chk("rd3_u1", dout1, 48'h1234_DEAD_BEEF);
    chk("rd3_mdl", exp1, 48'h1234_DEAD_BEEF);
    drive(0, 0, 0, '0, 0, 1);
    chk("rd3_lat2_u2", dout2, 48'h1234_DEAD_BEEF);

    // no_change on write
    drive(1, 1, 5, 48'hAAAA_5555_0F0F, 0, 1);
    chk("nochg_u1", dout1, 48'h1234_DEAD_BEEF);
    chk("nochg_u2", dout2, 48'h1234_DEAD_BEEF);

    // streaming
    for (int i = 0; i < 8; i++) drive(1, 1, i, DW'(i * 3), 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, i, '0, 0, 1);
      chk("stream_u1", dout1, DW'(i * 3));
      if (i > 0) chk("stream_u2", dout2, DW'((i - 1) * 3));
    end
    drive(0, 0, 0, '0, 0, 1);
    chk("stream_u2_last", dout2, 48'd21);

    // idle and sleep block writes and hold douta
    drive(0, 1, 2, 48'hBAD, 0, 1);
    chk("idle_hold_u1", dout1, 48'd21);
    drive(1, 1, 2, 48'hBAD, 1, 1);
    chk("sleep_hold_u1", dout1, 48'd21);
    drive(1, 0, 2, '0, 0, 1);
    chk("sleep_mem2_u1", dout1, 48'd6);
    drive(0, 0, 0, '0, 0, 1);
    chk("sleep_mem2_u2", dout2, 48'd6);

    // latency 2 with regcea low holds
    drive(1, 1, 1, 48'h0000_0001_1111, 0, 1);
    drive(1, 0, 1, '0, 0, 1);
    drive(0, 0, 0, '0, 0, 0);
    chk("rce0_hold_u2", dout2, 48'd6);

    // reset between the two latency-2 edges discards the read
    drive(1, 0, 1, '0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_u2", dout2, RRV);
    chk("midrst_u1", dout1, RRV);
    drive(0, 0, 0, '0, 0, 1);
    rst_n = 1'b1;
    drive(0, 0, 0, '0, 0, 1);
    chk("postrst_u2", dout2, RRV);
    drive(1, 0, 1, '0, 0, 1);
    drive(0, 0, 0, '0, 0, 1);
    chk("postrst_rd_u2", dout2, 48'h0000_0001_1111);

    // out of range for the 1000-deep instance only
    drive(1, 1, 1010, 48'h0BAD_F00D_CAFE, 0, 1);
    drive(1, 0, 1010, '0, 0, 1);
    chk("oor_u1", dout1, 48'h0BAD_F00D_CAFE);
    drive(0, 0, 0, '0, 0, 1);
    chk("oor_u2", dout2, 48'h0);

    // randomized traffic, occasional reset
    repeat (2000) begin
      rr = ($urandom_range(0, 149) == 0);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                       : int'($urandom_range(0, 15));
      sbit = ($urandom_range(0, 1) == 1);
      dbit = ($urandom_range(0, 1) == 1);
      if (rr) rst_n = 1'b0;
      drive(rr ? 1'b0 : ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ra,
            DW'({$urandom, $urandom}), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0));
      rst_n = 1'b1;
    end
    drive(0, 0, 0, '0, 0, 1);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
